// File: rtl/uart_json_motor_cmd.sv
`default_nettype none
// =====================================================================
// Module   : uart_json_motor_cmd
// Brief    : Formats signed wheel speeds into {"T":t,"L":x.xx,"R":y.yy}\n
//            frames streamed to a UART byte port. Optional idle heartbeat
//            resend is enabled by defining JSON_HEARTBEAT_EN.
// Revision : 1.0 - initial release
// =====================================================================
module uart_json_motor_cmd #(
   parameter int SPEED_W          = 8,
   parameter int TYPE_CODE        = 1,
   parameter int HEARTBEAT_CYCLES = 50_000_000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic signed [SPEED_W-1:0] left_speed,
   input  logic signed [SPEED_W-1:0] right_speed,
   output logic [7:0]                tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic                      busy
);
   typedef enum logic [0:0] {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

   typedef struct packed {
      logic       neg;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [7:0] d2;
   } field_t;

   localparam logic signed [SPEED_W-1:0] c_SPD_MAX   = SPEED_W'(100);
   localparam logic signed [SPEED_W-1:0] c_SPD_MIN   = SPEED_W'(-100);
   localparam logic [7:0]                c_TYPE_CHAR = 8'(48 + TYPE_CODE);
   localparam logic [4:0]                c_SLOT_LAST = 5'd27;

   state_t     r_state, w_state_nxt;
   field_t     r_lf, r_rf;
   logic [4:0] r_slot, w_slot_nxt;
   logic [7:0] w_byte_nxt;
   logic       w_hs, w_last, w_start_cmd, w_start_hb, w_start;

   // Clamp to +/-1.00 and split into ASCII sign/integer/tenths/hundredths
   function automatic field_t to_field(input logic signed [SPEED_W-1:0] v);
      logic signed [SPEED_W-1:0] c;
      logic [SPEED_W-1:0]        mag;
      logic [6:0]                m;
      logic [6:0]                rem;
      field_t                    f;
      if (v > c_SPD_MAX)      c = c_SPD_MAX;
      else if (v < c_SPD_MIN) c = c_SPD_MIN;
      else                    c = v;
      mag   = c[SPEED_W-1] ? -c : c;
      m     = 7'(mag);
      rem   = (m == 7'd100) ? 7'd0 : m;
      f.neg = c[SPEED_W-1];
      f.d0  = (m == 7'd100) ? 8'h31 : 8'h30;
      f.d1  = 8'h30 + 8'(rem / 7'd10);
      f.d2  = 8'h30 + 8'(rem % 7'd10);
      return f;
   endfunction

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state == S_SEND);

   assign w_hs        = tx_valid && tx_ready;
   assign w_last      = (r_slot == c_SLOT_LAST);
   assign w_start_cmd = (r_state == S_IDLE) && cmd_valid;
   assign w_start     = w_start_cmd || w_start_hb;

`ifdef JSON_HEARTBEAT_EN
   localparam int c_IDLE_W = (HEARTBEAT_CYCLES > 2) ? $clog2(HEARTBEAT_CYCLES) : 1;
   logic [c_IDLE_W-1:0] r_idle;

   assign w_start_hb = (r_state == S_IDLE) && !cmd_valid &&
                       (r_idle == c_IDLE_W'(HEARTBEAT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    r_idle <= '0;
      else if (w_start)           r_idle <= '0;
      else if (r_state == S_IDLE) r_idle <= r_idle + 1'b1;
   end
`else
   assign w_start_hb = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start)         w_state_nxt = S_SEND;
         S_SEND:  if (w_hs && w_last)  w_state_nxt = S_IDLE;
         default:                      w_state_nxt = S_IDLE;
      endcase
   end

   // Slot map covers the 28-byte worst case; minus slots skip when positive
   always_comb begin
      w_slot_nxt = r_slot + 5'd1;
      if (w_slot_nxt == 5'd11 && !r_lf.neg) w_slot_nxt = 5'd12;
      if (w_slot_nxt == 5'd21 && !r_rf.neg) w_slot_nxt = 5'd22;
   end

   always_comb begin
      w_byte_nxt = 8'h00;
      case (w_slot_nxt)
         5'd0:                                 w_byte_nxt = "{";
         5'd1, 5'd3, 5'd7, 5'd9, 5'd17, 5'd19: w_byte_nxt = "\"";
         5'd2:                                 w_byte_nxt = "T";
         5'd4, 5'd10, 5'd20:                   w_byte_nxt = ":";
         5'd5:                                 w_byte_nxt = c_TYPE_CHAR;
         5'd6, 5'd16:                          w_byte_nxt = ",";
         5'd8:                                 w_byte_nxt = "L";
         5'd11, 5'd21:                         w_byte_nxt = "-";
         5'd12:                                w_byte_nxt = r_lf.d0;
         5'd13, 5'd23:                         w_byte_nxt = ".";
         5'd14:                                w_byte_nxt = r_lf.d1;
         5'd15:                                w_byte_nxt = r_lf.d2;
         5'd18:                                w_byte_nxt = "R";
         5'd22:                                w_byte_nxt = r_rf.d0;
         5'd24:                                w_byte_nxt = r_rf.d1;
         5'd25:                                w_byte_nxt = r_rf.d2;
         5'd26:                                w_byte_nxt = "}";
         5'd27:                                w_byte_nxt = 8'h0a;
         default:                              w_byte_nxt = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_slot   <= 5'd0;
         r_lf     <= '{neg: 1'b0, d0: 8'h30, d1: 8'h30, d2: 8'h30};
         r_rf     <= '{neg: 1'b0, d0: 8'h30, d1: 8'h30, d2: 8'h30};
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start_cmd) begin
            r_lf <= to_field(left_speed);
            r_rf <= to_field(right_speed);
         end
         if (w_start) begin
            r_slot   <= 5'd0;
            tx_data  <= "{";
            tx_valid <= 1'b1;
         end else if (w_hs) begin
            if (w_last) begin
               tx_valid <= 1'b0;
            end else begin
               r_slot  <= w_slot_nxt;
               tx_data <= w_byte_nxt;
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_uart_json_motor_cmd.sv
`default_nettype none
// =====================================================================
// Module   : tb_uart_json_motor_cmd
// Brief    : Self-checking bench; a string-level frame model predicts every
//            byte, with literal frames pinning the model.
// Revision : 1.0 - initial release
// =====================================================================
module tb_uart_json_motor_cmd;
   localparam int SPEED_W   = 8;
   localparam int TYPE_CODE = 1;
   localparam int HB        = 100;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      cmd_valid;
   logic                      cmd_ready;
   logic signed [SPEED_W-1:0] left_speed;
   logic signed [SPEED_W-1:0] right_speed;
   logic [7:0]                tx_data;
   logic                      tx_valid;
   logic                      tx_ready;
   logic                      busy;

   uart_json_motor_cmd #(
      .SPEED_W(SPEED_W), .TYPE_CODE(TYPE_CODE), .HEARTBEAT_CYCLES(HB)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .left_speed(left_speed), .right_speed(right_speed),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   int         n_chk  = 0;
   int         n_pass = 0;
   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int         idle_cnt = 0;
   int         last_l = 0, last_r = 0;
   int         busy_cnt = 0;
   bit         stall = 0;
   logic [7:0] prev_data = 8'h00;
   bit         bp_en = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic string fmt_field(int v);
      int    c, m;
      string sg;
      c  = (v > 100) ? 100 : ((v < -100) ? -100 : v);
      m  = (c < 0) ? -c : c;
      sg = (c < 0) ? "-" : "";
      return $sformatf("%s%0d.%0d%0d", sg, m / 100, (m % 100) / 10, m % 10);
   endfunction

   function automatic string fmt_frame(int l, int r);
      return $sformatf("{\"T\":%0d,\"L\":%s,\"R\":%s}\n", TYPE_CODE, fmt_field(l), fmt_field(r));
   endfunction

   function automatic string esc(string s);
      string o = "";
      for (int i = 0; i < s.len(); i++)
         if (s[i] == 8'h0a) o = {o, "\\n"};
         else               o = {o, s.substr(i, i)};
      return o;
   endfunction

   task automatic push_frame(int l, int r);
      string s = fmt_frame(l, r);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
   endtask

   task automatic chk_str(input string name, input string act, input string exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got '%s', expected '%s'", name, esc(act), esc(exp));
   endtask

   task automatic chk_frame(input string name, input string exp);
      string rs = "";
      foreach (rx_q[i]) rs = $sformatf("%s%c", rs, rx_q[i]);
      chk_str(name, rs, exp);
   endtask

   // Model and per-cycle compare: IDLE is "nothing left to send"
   always @(negedge clk) begin
      bit model_idle;
      if (rst) begin
         exp_q.delete();
         idle_cnt = 0; last_l = 0; last_r = 0; stall = 0;
      end else begin
         model_idle = (exp_q.size() == 0);
         chk("tx_valid", 32'(tx_valid), 32'(!model_idle));
         chk("cmd_ready", 32'(cmd_ready), 32'(model_idle));
         chk("busy", 32'(busy), 32'(!model_idle));
         if (stall) begin
            chk("hold_valid", 32'(tx_valid), 32'd1);
            chk("hold_data", 32'(tx_data), 32'(prev_data));
         end
         if (tx_valid && !model_idle) chk("tx_data", 32'(tx_data), 32'(exp_q[0]));
         if (busy) busy_cnt++;
         stall     = tx_valid && !tx_ready;
         prev_data = tx_data;
         if (tx_valid && tx_ready) begin
            rx_q.push_back(tx_data);
            if (!model_idle) void'(exp_q.pop_front());
         end
         if (model_idle) begin
            if (cmd_valid) begin
               last_l = left_speed; last_r = right_speed;
               push_frame(last_l, last_r);
               idle_cnt = 0;
            end
`ifdef JSON_HEARTBEAT_EN
            else if (idle_cnt == HB - 1) begin
               push_frame(last_l, last_r);
               idle_cnt = 0;
            end else idle_cnt++;
`endif
         end
      end
   end

   always @(posedge clk) if (bp_en) #1 tx_ready = 1'($urandom_range(0, 1));

   task automatic send_cmd(input int l, input int r);
      int n = 0;
      rx_q.delete();
      busy_cnt = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; left_speed = SPEED_W'(l); right_speed = SPEED_W'(r);
      do begin @(negedge clk); n++; end while (!cmd_ready && n < 500);
      if (n >= 500) chk("cmd_accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("first_byte", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h7b});
   endtask

   task automatic wait_done();
      int n = 0;
      do begin @(posedge clk); #1; n++; end
      while ((exp_q.size() != 0 || tx_valid) && n < 3000);
      if (n >= 3000) chk("frame_done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int n;
      rst = 1'b1; cmd_valid = 1'b0; left_speed = '0; right_speed = '0; tx_ready = 1'b1;
      #1;
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk_str("model_pin_a", fmt_frame(-50, 50), "{\"T\":1,\"L\":-0.50,\"R\":0.50}\n");
      chk_str("model_pin_b", fmt_frame(127, -128), "{\"T\":1,\"L\":1.00,\"R\":-1.00}\n");
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      rx_q.delete();

`ifdef JSON_HEARTBEAT_EN
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!tx_valid && n < 300);
      chk("hb_first_delay", 32'(n), 32'd100);
      wait_done();
      chk_frame("hb_stop_frame", "{\"T\":1,\"L\":0.00,\"R\":0.00}\n");
`endif

      send_cmd(-50, 50);
      wait_done();
      chk_frame("frame_m50_p50", "{\"T\":1,\"L\":-0.50,\"R\":0.50}\n");
      chk("busy_cycles", 32'(busy_cnt), 32'd27);

      send_cmd(127, -128);
      wait_done();
      chk_frame("frame_clamp", "{\"T\":1,\"L\":1.00,\"R\":-1.00}\n");

      send_cmd(0, -5);
      wait_done();
      chk_frame("frame_0_m5", "{\"T\":1,\"L\":0.00,\"R\":-0.05}\n");
      chk("busy_cycles_27", 32'(busy_cnt), 32'd27);

      send_cmd(3, 7);
      wait_done();
      chk("busy_cycles_26", 32'(busy_cnt), 32'd26);

      bp_en = 1'b1;
      send_cmd(-37, 99);
      repeat (3) @(posedge clk);
      #1 cmd_valid = 1'b1; left_speed = 8'sd20; right_speed = 8'sd20;
      repeat (2) @(posedge clk);
      #1 cmd_valid = 1'b0;
      wait_done();
      bp_en = 1'b0;
      @(posedge clk); #1 tx_ready = 1'b1;
      chk_frame("frame_backpressure", "{\"T\":1,\"L\":-0.37,\"R\":0.99}\n");

      @(posedge clk); #1;
      cmd_valid = 1'b1; left_speed = 8'sd30; right_speed = -8'sd30;
      repeat (60) @(posedge clk);
      #1 cmd_valid = 1'b0;
      wait_done();

      send_cmd(1, 2);
      n = 0;
      do begin @(negedge clk); n++; end while (rx_q.size() < 10 && n < 200);
      @(posedge clk); #1 rst = 1'b1;
      #1;
      chk("abort_tx_valid", 32'(tx_valid), 32'd0);
      chk("abort_tx_data", 32'(tx_data), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      send_cmd(-100, 100);
      wait_done();
      chk_frame("frame_after_abort", "{\"T\":1,\"L\":-1.00,\"R\":1.00}\n");

`ifdef JSON_HEARTBEAT_EN
      send_cmd(10, 10);
      wait_done();
      rx_q.delete();
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!tx_valid && n < 300);
      chk("hb_repeat_delay", 32'(n), 32'd100);
      wait_done();
      chk_frame("hb_repeat_frame", "{\"T\":1,\"L\":0.10,\"R\":0.10}\n");
      rx_q.delete();
      n = 0;
      do begin @(posedge clk); #1; n++; end while (idle_cnt != HB - 1 && n < 300);
      cmd_valid = 1'b1; left_speed = 8'sd25; right_speed = -8'sd3;
      @(posedge clk); #1 cmd_valid = 1'b0;
      wait_done();
      chk_frame("hb_trigger_cmd_wins", "{\"T\":1,\"L\":0.25,\"R\":-0.03}\n");
`else
      n = 0;
      for (int i = 0; i < 10000; i++) begin
         @(posedge clk); #1;
         if (tx_valid) n++;
      end
      chk("no_heartbeat", 32'(n), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
